// File: rtl/gen_reset_seq.sv
// Multi-channel reset sequencer: staggered synchronous release of NUM_CH resets after lock.
// Optional lock debounce enabled by defining GEN_RESET_LOCK_DEBOUNCE_EN.
module gen_reset_seq #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CTR_WIDTH   = 24,
  parameter int unsigned BASE_CNT    = 1048575,
  parameter int unsigned STAGGER_CNT = 256,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_FILT   = 64
) (
  input  logic              tx_clk,
  input  logic              reset_in,
  input  logic              lock_in,
  input  logic              sw_reset,
  output logic [NUM_CH-1:0] reset_out,
  output logic              done
);

  localparam longint unsigned TH_MAX =
    64'(BASE_CNT) + 64'(NUM_CH - 1) * 64'(STAGGER_CNT);

  // Configuration sanity: counter must reach the last threshold without wrapping
  if (NUM_CH < 1 || NUM_CH > 16 || SYNC_STAGES < 2 || LOCK_FILT < 1 ||
      TH_MAX >= (64'd1 << CTR_WIDTH)) begin : g_cfg_err
    $error("gen_reset_seq: illegal parameter set (CTR_WIDTH too small or range error)");
  end

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    WAIT_LOCK = 2'd1,
    COUNT     = 2'd2,
    RUN       = 2'd3
  } state_t;

  function automatic logic [CTR_WIDTH-1:0] th(input int unsigned idx);
    return CTR_WIDTH'(64'(BASE_CNT) + 64'(idx) * 64'(STAGGER_CNT));
  endfunction

  logic [SYNC_STAGES-1:0] rst_sync_q;
  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic                   rst_s;
  logic                   lock_s;
  logic                   lock_ok;

  state_t                 state, state_d;
  logic [CTR_WIDTH-1:0]   ctr, ctr_d;
  logic [NUM_CH-1:0]      rst_out_d;
  logic                   done_d;
  logic                   abort;

  // Release synchroniser: set on reset, shifts in zeros afterwards
  always_ff @(posedge tx_clk or posedge reset_in) begin
    if (reset_in) rst_sync_q <= '1;
    else          rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], 1'b0};
  end

  always_ff @(posedge tx_clk or posedge reset_in) begin
    if (reset_in) lock_sync_q <= '0;
    else          lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], lock_in};
  end

  assign rst_s  = rst_sync_q[SYNC_STAGES-1];
  assign lock_s = lock_sync_q[SYNC_STAGES-1];

`ifdef GEN_RESET_LOCK_DEBOUNCE_EN
  localparam int unsigned LF_W = $clog2(LOCK_FILT + 1);
  logic [LF_W-1:0] lock_cnt;

  // Counts consecutive locked cycles, saturating at LOCK_FILT
  always_ff @(posedge tx_clk or posedge reset_in) begin
    if (reset_in)                          lock_cnt <= '0;
    else if (!lock_s)                      lock_cnt <= '0;
    else if (lock_cnt != LF_W'(LOCK_FILT)) lock_cnt <= lock_cnt + LF_W'(1);
  end

  assign lock_ok = lock_s && (lock_cnt >= LF_W'(LOCK_FILT - 1));
`else
  assign lock_ok = lock_s;
`endif

  assign abort = sw_reset || !lock_s;

  always_ff @(posedge tx_clk or posedge reset_in) begin
    if (reset_in) begin
      state     <= HOLD;
      ctr       <= '0;
      reset_out <= '1;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      ctr       <= ctr_d;
      reset_out <= rst_out_d;
      done      <= done_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state;
    ctr_d     = ctr;
    rst_out_d = '1;
    done_d    = 1'b0;
    case (state)
      HOLD: begin
        if (!rst_s) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        ctr_d = '0;
        if (lock_ok && !sw_reset) state_d = COUNT;
      end
      COUNT: begin
        if (abort) begin
          state_d = WAIT_LOCK;
          ctr_d   = '0;
        end else begin
          ctr_d = ctr + CTR_WIDTH'(1);
          for (int unsigned i = 0; i < NUM_CH; i++) begin
            rst_out_d[i] = ~(ctr >= th(i));
          end
          if (ctr == CTR_WIDTH'(TH_MAX)) begin
            state_d = RUN;
            ctr_d   = ctr;
            done_d  = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d = WAIT_LOCK;
          ctr_d   = '0;
        end else begin
          rst_out_d = '0;
          done_d    = 1'b1;
        end
      end
      default: state_d = HOLD;
    endcase
  end

endmodule

// File: tb/tb_gen_reset_seq.sv
// Directed self-checking bench for gen_reset_seq (NUM_CH=4, BASE=16, STAGGER=4, CTR_WIDTH=8).
module tb_gen_reset_seq;

  logic       tx_clk;
  logic       reset_in;
  logic       lock_in;
  logic       sw_reset;
  logic [3:0] reset_out;
  logic       done;

  int checks = 0;
  int errors = 0;

`ifdef GEN_RESET_LOCK_DEBOUNCE_EN
  localparam int unsigned RST_ENTRY  = 10;
  localparam int unsigned LOCK_ENTRY = 10;
`else
  localparam int unsigned RST_ENTRY  = 4;
  localparam int unsigned LOCK_ENTRY = 3;
`endif

  gen_reset_seq #(
    .NUM_CH(4), .CTR_WIDTH(8), .BASE_CNT(16), .STAGGER_CNT(4),
    .SYNC_STAGES(2), .LOCK_FILT(8)
  ) dut (
    .tx_clk(tx_clk), .reset_in(reset_in), .lock_in(lock_in),
    .sw_reset(sw_reset), .reset_out(reset_out), .done(done)
  );

  initial tx_clk = 1'b0;
  always #5 tx_clk = ~tx_clk;

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge tx_clk);
    #1;
  endtask

  // Compares {done, reset_out} against a hand-computed value
  task automatic chk(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {done, reset_out};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called on the COUNT-entry edge; checks releases at relative edges 17,21,25,29
  task automatic check_release(input string tag);
    tick(16); chk({tag, "_e16"}, 5'h0F);
    tick(1);  chk({tag, "_e17"}, 5'h0E);
    tick(3);  chk({tag, "_e20"}, 5'h0E);
    tick(1);  chk({tag, "_e21"}, 5'h0C);
    tick(3);  chk({tag, "_e24"}, 5'h0C);
    tick(1);  chk({tag, "_e25"}, 5'h08);
    tick(3);  chk({tag, "_e28"}, 5'h08);
    tick(1);  chk({tag, "_e29"}, 5'h10);
    tick(5);  chk({tag, "_run"}, 5'h10);
  endtask

  initial begin
    reset_in = 1'b1;
    lock_in  = 1'b1;
    sw_reset = 1'b0;

    // Test 1: reset pulse with lock held
    #2; chk("t1_async_set", 5'h0F);
    tick(2); chk("t1_in_reset", 5'h0F);
    reset_in = 1'b0;
    tick(RST_ENTRY - 1); chk("t1_pre_count", 5'h0F);
    tick(1);
    check_release("t1");

    // Test 2: no lock for 100 cycles, then lock
    lock_in = 1'b0;
    reset_in = 1'b1; #2; chk("t2_async_set", 5'h0F);
    reset_in = 1'b0;
    tick(100); chk("t2_no_lock", 5'h0F);
    lock_in = 1'b1;
    tick(LOCK_ENTRY - 1); chk("t2_pre_count", 5'h0F);
    tick(1);
    check_release("t2");

    // Test 3: one-cycle sw_reset in RUN, then held sw_reset
    sw_reset = 1'b1;
    tick(1); chk("t3_abort", 5'h0F);
    sw_reset = 1'b0;
    tick(1);
    check_release("t3");
    sw_reset = 1'b1;
    tick(30); chk("t3_sw_held", 5'h0F);
    sw_reset = 1'b0;
    tick(1);

    // Test 4: lock loss at ctr=22
    tick(22); chk("t4_ctr22", 5'h0C);
    lock_in = 1'b0;
    tick(2); chk("t4_lock_sync", 5'h0C);
    tick(1); chk("t4_abort", 5'h0F);
    lock_in = 1'b1;
    tick(LOCK_ENTRY - 1); chk("t4_pre_count", 5'h0F);
    tick(1);
    check_release("t4");

    // Test 5: async reset mid-COUNT
    sw_reset = 1'b1;
    tick(1);
    sw_reset = 1'b0;
    tick(1);
    tick(22); chk("t5_mid_count", 5'h0C);
    #3; reset_in = 1'b1;
    #1; chk("t5_async_set", 5'h0F);
    #2; reset_in = 1'b0;
    tick(RST_ENTRY - 1); chk("t5_pre_count", 5'h0F);
    tick(1);
    check_release("t5");

`ifdef GEN_RESET_LOCK_DEBOUNCE_EN
    // Test 6: lock glitch shorter than the filter is ignored
    lock_in = 1'b0;
    tick(3); chk("t6_abort", 5'h0F);
    tick(5);
    lock_in = 1'b1;
    tick(5);
    lock_in = 1'b0;
    tick(40); chk("t6_glitch", 5'h0F);
    lock_in = 1'b1;
    tick(LOCK_ENTRY - 1); chk("t6_pre_count", 5'h0F);
    tick(1);
    check_release("t6");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
